// File: rtl/matrix_inv_check_if.sv
// Handshake and data bundle between a 2x2 inverse producer and the inverse checker.
interface matrix_inv_check_if #(
    parameter int unsigned WIDTH = 16
);
    logic                    start;
    logic signed [WIDTH-1:0] a, b, c, d;
    logic signed [WIDTH-1:0] a_inv, b_inv, c_inv, d_inv;
    logic                    inv_error;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH-1:0] p00, p01, p10, p11;
    logic                    pass;
    logic                    fail;
    logic                    skipped;

    // Requester side: issues checks and observes results
    modport master (
        output start, a, b, c, d, a_inv, b_inv, c_inv, d_inv, inv_error,
        input  busy, done, p00, p01, p10, p11, pass, fail, skipped
    );

    // Checker side
    modport slave (
        input  start, a, b, c, d, a_inv, b_inv, c_inv, d_inv, inv_error,
        output busy, done, p00, p01, p10, p11, pass, fail, skipped
    );
endinterface

// File: rtl/matrix_inv_check.sv
// Multiplies A by its candidate inverse with one shared multiplier (8 cycles)
// and reports whether the product lies within TOL LSBs of the identity.
module matrix_inv_check #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 14,
    parameter int unsigned TOL   = 16
) (
    input  logic              clk,
    input  logic              reset,
    matrix_inv_check_if.slave bus
);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned ACC_W = 2 * WIDTH + 1;
    localparam int unsigned DW    = WIDTH + 2;

    localparam logic signed [ACC_W-1:0] ROUND   = ACC_W'(1) << (FRAC - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (WIDTH - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [DW-1:0]    ONE_D   = DW'(1) << FRAC;
    localparam logic signed [DW-1:0]    TOL_D   = DW'(TOL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_CMP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              k_q, k_d;
    logic                    err_q, err_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    // m = {a,b,c,d}, n = {a_inv,b_inv,c_inv,d_inv}, p = {p00,p01,p10,p11}
    logic signed [WIDTH-1:0] m_q [4];
    logic signed [WIDTH-1:0] m_d [4];
    logic signed [WIDTH-1:0] n_q [4];
    logic signed [WIDTH-1:0] n_d [4];
    logic signed [WIDTH-1:0] p_q [4];
    logic signed [WIDTH-1:0] p_d [4];
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic                    fail_q, fail_d;
    logic                    skipped_q, skipped_d;

    logic signed [WIDTH-1:0] op_x, op_y;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;
    logic signed [WIDTH-1:0] scaled;
    logic                    in_tol;

    // |x| <= TOL at widened precision so differences never wrap
    function automatic logic within_tol(input logic signed [DW-1:0] x);
        logic signed [DW-1:0] mag;
        mag = x[DW-1] ? -x : x;
        return mag <= TOL_D;
    endfunction

    // Shared MAC datapath: k = {row, col, term} selects x = m[2*row+term], y = n[2*term+col]
    always_comb begin
        op_x     = m_q[{k_q[2], k_q[0]}];
        op_y     = n_q[{k_q[0], k_q[1]}];
        prod     = PW'(op_x) * PW'(op_y);
        prod_ext = ACC_W'(prod);
        sum      = acc_q + prod_ext;
        shifted  = (sum + ROUND) >>> FRAC;
        if (shifted > SAT_MAX) begin
            scaled = WIDTH'(SAT_MAX);
        end else if (shifted < SAT_MIN) begin
            scaled = WIDTH'(SAT_MIN);
        end else begin
            scaled = WIDTH'(shifted);
        end
        in_tol = within_tol(DW'(p_q[0]) - ONE_D) &
                 within_tol(DW'(p_q[1])) &
                 within_tol(DW'(p_q[2])) &
                 within_tol(DW'(p_q[3]) - ONE_D);
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        err_d     = err_q;
        acc_d     = acc_q;
        m_d       = m_q;
        n_d       = n_q;
        p_d       = p_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        fail_d    = fail_q;
        skipped_d = skipped_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    m_d[0]    = bus.a;
                    m_d[1]    = bus.b;
                    m_d[2]    = bus.c;
                    m_d[3]    = bus.d;
                    n_d[0]    = bus.a_inv;
                    n_d[1]    = bus.b_inv;
                    n_d[2]    = bus.c_inv;
                    n_d[3]    = bus.d_inv;
                    err_d     = bus.inv_error;
                    for (int i = 0; i < 4; i++) begin
                        p_d[i] = '0;
                    end
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    skipped_d = 1'b0;
                    busy_d    = 1'b1;
                    k_d       = 3'd0;
                    acc_d     = '0;
                    state_d   = bus.inv_error ? S_CMP : S_MUL;
                end
            end
            S_MUL: begin
                if (!k_q[0]) begin
                    acc_d = prod_ext;
                end else begin
                    acc_d = sum;
                    p_d[k_q[2:1]] = scaled;
                end
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (err_q) begin
                    skipped_d = 1'b1;
                end else begin
                    pass_d = in_tol;
                    fail_d = ~in_tol;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            err_q     <= 1'b0;
            acc_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                m_q[i] <= '0;
                n_q[i] <= '0;
                p_q[i] <= '0;
            end
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            skipped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            err_q     <= err_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            n_q       <= n_d;
            p_q       <= p_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            skipped_q <= skipped_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.p00     = p_q[0];
    assign bus.p01     = p_q[1];
    assign bus.p10     = p_q[2];
    assign bus.p11     = p_q[3];
    assign bus.pass    = pass_q;
    assign bus.fail    = fail_q;
    assign bus.skipped = skipped_q;

endmodule
